// File: rtl/seq_sort_pkg.sv
// Shared types and helpers for the sequential bubble-sort controller.
package seq_sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Index width for a frame of 'depth' entries; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/magnitude_comparator.sv
// Purely combinational unsigned magnitude comparator; exactly one output is high.
module magnitude_comparator #(
    parameter int unsigned WIDTH = 2
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             A_gt_B,
    output logic             A_eq_B,
    output logic             A_lt_B
);

    assign A_gt_B = (A > B);
    assign A_eq_B = (A == B);
    assign A_lt_B = (A < B);

endmodule

// File: rtl/seq_sort_ctrl.sv
// Frame collector that bubble-sorts DEPTH entries ascending through one shared
// comparator (one compare per cycle) and streams the sorted frame out.
module seq_sort_ctrl
    import seq_sort_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int unsigned   IW       = idx_width(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] ONE      = IW'(1);

    if (DEPTH < 2) begin : g_bad_depth
        $error("seq_sort_ctrl: DEPTH must be at least 2");
    end

    state_e          state_q, state_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d;
    logic [IW-1:0]   j_q, j_d;
    logic [IW-1:0]   limit_q, limit_d;
    logic            swap_seen_q, swap_seen_d;

    logic [WIDTH-1:0] mem [DEPTH];

    logic [IW-1:0]    j_next;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             cmp_gt, cmp_eq, cmp_lt;
    logic             load_we;
    logic             do_swap;
    logic             unused_cmp;

    assign j_next = j_q + ONE;
    assign cmp_a  = mem[j_q];
    assign cmp_b  = mem[j_next];

    magnitude_comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .A      (cmp_a),
        .B      (cmp_b),
        .A_gt_B (cmp_gt),
        .A_eq_B (cmp_eq),
        .A_lt_B (cmp_lt)
    );

    // Equal entries never swap, so only the strict greater-than result matters.
    assign unused_cmp = cmp_eq ^ cmp_lt;

    always_comb begin
        state_d     = state_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        j_d         = j_q;
        limit_d     = limit_q;
        swap_seen_d = swap_seen_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        out_data    = '0;
        busy        = 1'b0;
        load_we     = 1'b0;
        do_swap     = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load_we = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d    = '0;
                        j_d         = '0;
                        limit_d     = LAST_IDX;
                        swap_seen_d = 1'b0;
                        state_d     = SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + ONE;
                    end
                end
            end

            SORT: begin
                busy    = 1'b1;
                do_swap = cmp_gt;
                if (j_q == limit_q - ONE) begin
                    // A clean pass, or a pass of a single compare, ends the sort.
                    if (!(swap_seen_q || cmp_gt) || (limit_q == ONE)) begin
                        rd_idx_d = '0;
                        state_d  = DRAIN;
                    end else begin
                        limit_d     = limit_q - ONE;
                        j_d         = '0;
                        swap_seen_d = 1'b0;
                    end
                end else begin
                    j_d         = j_next;
                    swap_seen_d = swap_seen_q | cmp_gt;
                end
            end

            DRAIN: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = mem[rd_idx_q];
                out_last  = (rd_idx_q == LAST_IDX);
                if (out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        wr_idx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + ONE;
                    end
                end
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            j_q         <= '0;
            limit_q     <= '0;
            swap_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            j_q         <= j_d;
            limit_q     <= limit_d;
            swap_seen_q <= swap_seen_d;
        end
    end

    // Storage is never reset; it is always reloaded before it can be read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_we) begin
                mem[wr_idx_q] <= in_data;
            end else if (do_swap) begin
                mem[j_q]    <= cmp_b;
                mem[j_next] <= cmp_a;
            end
        end
    end

endmodule

// File: tb/tb_seq_sort_ctrl.sv
// Directed bench for seq_sort_ctrl (DEPTH=4, WIDTH=2).
module tb_seq_sort_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_data = 2'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [1:0] out_data;
    logic       out_last;
    logic       busy;

    int   n_vec = 0;
    int   n_err = 0;
    logic hold_valid = 1'b0;

    always #5 clk = ~clk;

    seq_sort_ctrl #(
        .DEPTH (4),
        .WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [1:0] a, input logic [1:0] b,
                              input logic [1:0] c, input logic [1:0] d);
        logic [1:0] v [4];
        v = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            chk("load_in_ready", {31'd0, in_ready}, 32'd1);
            chk("load_busy", {31'd0, busy}, 32'd0);
            step();
        end
        in_valid = hold_valid;
        in_data  = 2'd3;
    endtask

    task automatic sort_wait(input int exp_cycles);
        int n;
        n = 0;
        while (!out_valid && n < 64) begin
            chk("sort_in_ready", {31'd0, in_ready}, 32'd0);
            chk("sort_busy", {31'd0, busy}, 32'd1);
            step();
            n++;
        end
        chk("sort_cycles", n, exp_cycles);
    endtask

    task automatic drain(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                         input logic [1:0] d, input int stall);
        logic [1:0] e [4];
        e = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < ((i == 0) ? 0 : stall); s++) begin
                out_ready = 1'b0;
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_data", {30'd0, out_data}, {30'd0, e[i]});
                chk("stall_last", {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
                chk("stall_busy", {31'd0, busy}, 32'd1);
                step();
            end
            out_ready = 1'b1;
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("out_data", {30'd0, out_data}, {30'd0, e[i]});
            chk("out_last", {31'd0, out_last}, (i == 3) ? 32'd1 : 32'd0);
            chk("out_busy", {31'd0, busy}, 32'd1);
            chk("out_in_ready", {31'd0, in_ready}, 32'd0);
            step();
            out_ready = 1'b0;
        end
        chk("post_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_busy", {31'd0, busy}, 32'd0);
        chk("post_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", {30'd0, out_data}, 32'd0);

        // Reverse order: full six-compare sort
        load_frame(2'd3, 2'd2, 2'd1, 2'd0);
        sort_wait(6);
        drain(2'd0, 2'd1, 2'd2, 2'd3, 0);

        // Already sorted: single clean pass
        load_frame(2'd0, 2'd1, 2'd2, 2'd3);
        sort_wait(3);
        drain(2'd0, 2'd1, 2'd2, 2'd3, 0);

        // Duplicates
        load_frame(2'd2, 2'd2, 2'd0, 2'd2);
        sort_wait(6);
        drain(2'd0, 2'd2, 2'd2, 2'd2, 0);

        // Backpressure: out_ready pattern 1,0,0,1,0,0,...
        load_frame(2'd1, 2'd3, 2'd0, 2'd2);
        sort_wait(6);
        drain(2'd0, 2'd1, 2'd2, 2'd3, 2);

        // Reset during the second SORT cycle
        load_frame(2'd3, 2'd2, 2'd1, 2'd0);
        chk("midsort_busy", {31'd0, busy}, 32'd1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        load_frame(2'd1, 2'd0, 2'd3, 2'd2);
        sort_wait(5);
        drain(2'd0, 2'd1, 2'd2, 2'd3, 0);

        // Back-to-back frames with in_valid held high and junk data while busy
        hold_valid = 1'b1;
        load_frame(2'd3, 2'd0, 2'd2, 2'd1);
        sort_wait(6);
        drain(2'd0, 2'd1, 2'd2, 2'd3, 1);
        load_frame(2'd1, 2'd1, 2'd0, 2'd0);
        sort_wait(6);
        drain(2'd0, 2'd0, 2'd1, 2'd1, 0);
        hold_valid = 1'b0;
        in_valid   = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_sort_ctrl.md
Name: seq_sort_ctrl

Overview:
Collects a frame of DEPTH unsigned WIDTH-bit values, sorts it ascending, then streams the sorted frame out. Sorting is bubble sort, sequenced through one shared magnitude comparator at one compare per cycle. The block sits between a valid/ready producer and a valid/ready consumer.

Parameters:
DEPTH, 4, entries per frame; must be >= 2, elaboration error otherwise.
WIDTH, 2, bits per unsigned entry.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  producer has a value on in_data.
in_ready  output  1  block accepts a value this cycle.
in_data  input  WIDTH  unsigned value to load.
out_valid  output  1  out_data holds a sorted entry.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  WIDTH  sorted entry, smallest first.
out_last  output  1  marks the final entry of the frame.
busy  output  1  high in SORT and DRAIN.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to LOAD; write index, read index, pass limit and swap flag are cleared.
  - Outputs after reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
  - Storage contents are not cleared and are never observable before they are reloaded.
- Reset mid-operation (LOAD, SORT or DRAIN): the frame is abandoned, state returns to LOAD, and no further outputs are produced for that frame.
- States: LOAD, SORT, DRAIN. The state type is encoded as an enum.
- LOAD:
  - in_ready=1.
  - A transfer happens when in_valid and in_ready are both high: in_data is written to mem[wr_idx] and wr_idx increments.
  - The DEPTH-th transfer moves the block to SORT on the next cycle, with j=0, limit=DEPTH-1 and swap_seen=0.
- SORT:
  - in_ready=0 and in_valid is ignored.
  - Each cycle the comparator sees A=mem[j] and B=mem[j+1].
  - If A_gt_B, the two entries swap at the clock edge. If equal or less, there is no swap, which keeps the sort stable.
  - If j < limit-1: j increments.
  - If j == limit-1 (end of pass): when no swap occurred in this pass (including the current cycle's compare) or limit==1, go to DRAIN. Otherwise set limit to limit-1, j to 0, clear swap_seen and start the next pass.
  - SORT length: DEPTH-1 cycles minimum (input already sorted), DEPTH*(DEPTH-1)/2 cycles maximum.
- DRAIN:
  - out_valid=1, out_data=mem[rd_idx], out_last=(rd_idx==DEPTH-1).
  - A transfer happens when out_valid and out_ready are both high; rd_idx then increments.
  - While out_ready=0, out_data and out_last hold steady.
  - The transfer with out_last=1 returns the block to LOAD on the next cycle, with in_ready=1 and indices cleared.
- Timing:
  - out_valid rises the cycle after the final SORT cycle.
  - A new frame can be accepted the cycle after the last output transfer; there is no overlap of frames.
- Width rules:
  - Indices are $clog2(DEPTH) bits wide.
  - Comparisons are unsigned at full WIDTH; there is no truncation.
- busy=1 exactly while in SORT or DRAIN.

Decomposition:
- seq_sort_pkg holds:
  - the state enum typedef (LOAD, SORT, DRAIN);
  - an index-width localparam function based on $clog2.
- One sub-module: magnitude_comparator, parameterised on WIDTH.
  - Inputs A, B; outputs A_gt_B, A_eq_B, A_lt_B, exactly one of them high.
  - It is purely combinational and instantiated once as the shared compare resource.

Test Plan:
- Reverse order, DEPTH=4, WIDTH=2: load 3,2,1,0 -> SORT lasts 6 cycles; out 0,1,2,3 with out_last only on the value 3.
- Already sorted: load 0,1,2,3 -> SORT lasts 3 cycles (early exit); out 0,1,2,3.
- Duplicates: load 2,2,0,2 -> out 0,2,2,2, with no swaps between the equal entries.
- Backpressure: after loading 1,3,0,2, toggle out_ready 1,0,0,1,... -> out 0,1,2,3; out_data/out_last stay stable while stalled; busy=1 until the last transfer.
- Reset mid-SORT: assert rst during the 2nd SORT cycle -> next cycle in_ready=1, out_valid=0, busy=0; a fresh load of 1,0,3,2 then gives out 0,1,2,3.
- Back-to-back frames with in_valid held high: frame 3,0,2,1 then frame 1,1,0,0 -> out 0,1,2,3 then 0,0,1,1; in_ready=0 throughout SORT/DRAIN and in_data is ignored there.
